// File: rtl/sg_desc_writer.sv
// AXI4 write master that fills a ring of AXI DMA scatter-gather descriptors,
// one 8-beat INCR burst per descriptor, then pulses done.
module sg_desc_writer #(
  parameter int CNT_W = 8
) (
  input  logic             s_aclk,
  input  logic             s_aresetn,
  input  logic             start,
  input  logic [31:0]      desc_base,
  input  logic [31:0]      buf_base,
  input  logic [31:0]      buf_stride,
  input  logic [25:0]      xfer_len,
  input  logic [CNT_W-1:0] desc_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       m_axi_awid,
  output logic [31:0]      m_axi_awaddr,
  output logic [7:0]       m_axi_awlen,
  output logic [2:0]       m_axi_awsize,
  output logic [1:0]       m_axi_awburst,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wlast,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [3:0]       m_axi_bid,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, desc_addr_q, buf_addr_q, stride_q;
  logic [25:0]      len_q;
  logic [CNT_W-1:0] count_q, idx_q, last_idx;
  logic [2:0]       beat_q;
  logic             error_q;
  logic             last_desc;
  logic [31:0]      nxtdesc;
  logic             unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign last_idx  = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_desc = (idx_q == last_idx);
  // Ring closure: the final descriptor chains back to descriptor 0.
  assign nxtdesc   = last_desc ? base_q : desc_addr_q + 32'd64;

  assign m_axi_awid    = 4'd0;
  assign m_axi_awlen   = 8'd7;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awaddr  = desc_addr_q;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (desc_count == '0) ? S_DONE : S_AW;
      S_AW:   if (m_axi_awready) state_d = S_W;
      S_W:    if (m_axi_wready && beat_q == 3'd7) state_d = S_B;
      S_B:    if (m_axi_bvalid)
                state_d = (m_axi_bresp != 2'b00 || last_desc) ? S_DONE : S_AW;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    error         = error_q;
    m_axi_awvalid = (state_q == S_AW);
    m_axi_wvalid  = (state_q == S_W);
    m_axi_wlast   = (state_q == S_W) && (beat_q == 3'd7);
    m_axi_bready  = (state_q == S_B);
    m_axi_wdata   = 32'd0;
    if (state_q == S_W) begin
      case (beat_q)
        3'd0:    m_axi_wdata = nxtdesc;
        3'd2:    m_axi_wdata = buf_addr_q;
        3'd6:    m_axi_wdata = {4'b0000, 2'b11, len_q};
        default: m_axi_wdata = 32'd0;
      endcase
    end
  end

  // Running adders step descriptor and buffer addresses; no multiplier.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      base_q      <= '0;
      desc_addr_q <= '0;
      buf_addr_q  <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          base_q      <= desc_base;
          desc_addr_q <= desc_base;
          buf_addr_q  <= buf_base;
          stride_q    <= buf_stride;
          len_q       <= xfer_len;
          count_q     <= desc_count;
          idx_q       <= '0;
          beat_q      <= '0;
          error_q     <= 1'b0;
        end
        S_AW: beat_q <= '0;
        S_W:  if (m_axi_wready) beat_q <= beat_q + 3'd1;
        S_B:  if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            error_q <= 1'b1;
          end else if (!last_desc) begin
            idx_q       <= idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
            desc_addr_q <= desc_addr_q + 32'd64;
            buf_addr_q  <= buf_addr_q + stride_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sg_desc_writer.sv
// Randomized self-checking bench for sg_desc_writer: AXI slave model plus a
// queue-based descriptor model built from plain address arithmetic.
module tb_sg_desc_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] desc_base = '0, buf_base = '0, buf_stride = '0;
  logic [25:0] xfer_len = '0;
  logic [7:0]  desc_count = '0;
  logic        busy, done, error;
  logic [3:0]  awid;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, wlast, wvalid, bready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  wstrb;
  logic [3:0]  bid = 4'd0;
  logic [1:0]  bresp = 2'b00;

  sg_desc_writer #(.CNT_W(8)) dut (
    .s_aclk(clk), .s_aresetn(rst_n), .start(start), .desc_base(desc_base),
    .buf_base(buf_base), .buf_stride(buf_stride), .xfer_len(xfer_len),
    .desc_count(desc_count), .busy(busy), .done(done), .error(error),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model and monitor state
  logic [31:0] exp_a[$], exp_w[$], cap_a[$], cap_w[$];
  int  mbeat = 0, n_bursts = 0, done_cnt = 0;
  bit  aw_out, b_pend, b_hs, bp;
  bit  p_aw_stall, p_w_stall, p_wlast_hs, p_aw_hs, p_b_hs, p_done;
  logic [31:0] p_awaddr, p_wdata;
  logic p_wlast;
  int  err_at = -1, resp_n = 0;

  task automatic clear_mon();
    exp_a.delete(); exp_w.delete(); cap_a.delete(); cap_w.delete();
    mbeat = 0; n_bursts = 0; done_cnt = 0; resp_n = 0;
    aw_out = 0; b_pend = 0; b_hs = 0;
    p_aw_stall = 0; p_w_stall = 0; p_wlast_hs = 0; p_aw_hs = 0; p_b_hs = 0; p_done = 0;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (p_wlast_hs) chk("bready_rise", bready, 1);
    if (p_aw_hs)    chk("wvalid_rise", wvalid, 1);
    if (p_b_hs && exp_a.size() > 0) chk("awvalid_after_b", awvalid, 1);
    if (p_aw_stall) begin
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_stable", awaddr, p_awaddr);
    end
    if (p_w_stall) begin
      chk("wvalid_hold", wvalid, 1);
      chk("wdata_stable", wdata, p_wdata);
      chk("wlast_stable", wlast, p_wlast);
    end
    if (wvalid) chk("w_after_aw", aw_out, 1);
    if (done) begin done_cnt++; chk("done_one_cycle", p_done, 0); end
    p_aw_hs = 0; p_wlast_hs = 0; p_b_hs = 0;
    if (awvalid && awready) begin
      n_bursts++; cap_a.push_back(awaddr);
      chk("aw_expected", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) chk("awaddr", awaddr, exp_a.pop_front());
      chk("aw_attr", {15'd0, awid, awlen, awsize, awburst}, {15'd0, 4'd0, 8'd7, 3'd2, 2'd1});
      aw_out = 1; p_aw_hs = 1;
    end
    if (wvalid && wready) begin
      cap_w.push_back(wdata);
      chk("w_expected", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) chk("wdata", wdata, exp_w.pop_front());
      chk("wlast", wlast, mbeat == 7);
      chk("wstrb", wstrb, 4'hF);
      if (mbeat == 7) begin aw_out = 0; b_pend = 1; p_wlast_hs = 1; end
      mbeat = (mbeat + 1) % 8;
    end
    if (bvalid && bready) begin b_hs = 1; p_b_hs = 1; end
    p_aw_stall = awvalid && !awready; p_awaddr = awaddr;
    p_w_stall = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
    p_done = done;
  end

  // AXI slave: random ready stalls when bp is set, one B per burst
  initial forever begin
    @(posedge clk); #1;
    if (b_hs) begin bvalid = 0; b_hs = 0; end
    if (b_pend && !bvalid && (!bp || $urandom_range(0, 2) == 0)) begin
      bvalid = 1;
      bresp = (resp_n == err_at) ? 2'b10 : 2'b00;
      bid = 4'($urandom_range(0, 15));
      resp_n++; b_pend = 0;
    end
    awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic build(input logic [31:0] base, bbase, stride, input logic [25:0] len,
                       input int cnt, input int ea, output int n_exp);
    n_exp = (ea >= 0 && ea < cnt) ? ea + 1 : cnt;
    for (int i = 0; i < n_exp; i++) begin
      exp_a.push_back(base + 32'(64 * i));
      exp_w.push_back(base + 32'(64 * ((i + 1) % cnt)));
      exp_w.push_back(32'd0);
      exp_w.push_back(bbase + stride * 32'(i));
      exp_w.push_back(32'd0); exp_w.push_back(32'd0); exp_w.push_back(32'd0);
      exp_w.push_back({6'b000011, len});
      exp_w.push_back(32'd0);
    end
  endtask

  task automatic run_cmd(input logic [31:0] base, bbase, stride, input logic [25:0] len,
                         input int cnt, input int ea, input bit bp_in, input bit disturb);
    int n_exp, k;
    bit exp_err;
    clear_mon();
    err_at = ea; bp = bp_in;
    build(base, bbase, stride, len, cnt, ea, n_exp);
    exp_err = (ea >= 0 && ea < cnt);
    @(posedge clk); #1;
    desc_base = base; buf_base = bbase; buf_stride = stride; xfer_len = len;
    desc_count = 8'(cnt); start = 1;
    @(posedge clk); #1;
    start = 0;
    desc_base = $urandom() & 32'hFFFF_FFC0; buf_base = $urandom();
    buf_stride = $urandom(); xfer_len = 26'($urandom()); desc_count = 8'($urandom());
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    if (cnt > 0) chk("awvalid_first", awvalid, 1);
    k = 0;
    while (!done && k < 4000) begin
      @(negedge clk); k++;
      start = disturb && (k == 5);
    end
    start = 0;
    if (k >= 4000) chk("done_timeout", 0, 1);
    else begin
      if (cnt == 0) chk("count0_done_latency_ok", (k + 1) <= 2, 1);
      chk("error_at_done", error, exp_err);
      chk("busy_at_done", busy, 1);
      chk("bursts_issued", n_bursts, n_exp);
      chk("aw_model_drained", exp_a.size(), 0);
      chk("w_model_drained", exp_w.size(), 0);
      @(negedge clk);
      chk("done_fell", done, 0);
      chk("busy_fell", busy, 0);
      chk("error_held", error, exp_err);
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_flags", {busy, done, error, awvalid, wvalid, wlast, bready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_consts", {awid, awlen, awsize, awburst, wstrb}, {4'd0, 8'd7, 3'd2, 2'd1, 4'hF});
  endtask

  task automatic chk_ring3();
    chk("lit_n_aw", cap_a.size(), 3);
    chk("lit_n_w", cap_w.size(), 24);
    if (cap_a.size() == 3 && cap_w.size() == 24) begin
      chk("lit_aw0", cap_a[0], 32'h1000);
      chk("lit_aw1", cap_a[1], 32'h1040);
      chk("lit_aw2", cap_a[2], 32'h1080);
      chk("lit_nxt0", cap_w[0], 32'h1040);
      chk("lit_nxt1", cap_w[8], 32'h1080);
      chk("lit_nxt2", cap_w[16], 32'h1000);
      chk("lit_buf0", cap_w[2], 32'h4000_0000);
      chk("lit_buf1", cap_w[10], 32'h4000_0400);
      chk("lit_buf2", cap_w[18], 32'h4000_0800);
      chk("lit_ctrl", cap_w[6], 32'h0C00_0100);
      chk("lit_status", cap_w[7], 32'h0);
    end
  endtask

  initial begin
    int k;
    clear_mon();
    #12;
    chk_reset_outs();
    @(negedge clk); #2 rst_n = 1;
    repeat (4) @(negedge clk);
    #2 rst_n = 0; #1;
    chk_reset_outs();
    @(negedge clk); #2 rst_n = 1;
    repeat (2) @(negedge clk);

    run_cmd(32'h1000, 32'h4000_0000, 32'h400, 26'h100, 3, -1, 0, 1);
    chk_ring3();
    run_cmd(32'h1000, 32'h4000_0000, 32'h400, 26'h100, 3, -1, 1, 1);
    chk_ring3();
    run_cmd(32'h8000, 32'h1000_0000, 32'h100, 26'h40, 4, 1, 0, 0);
    chk("abort_bursts", n_bursts, 2);
    run_cmd(32'h2000, 32'h5000_0000, 32'h80, 26'h20, 0, -1, 0, 0);
    chk("count0_no_aw", n_bursts, 0);
    run_cmd(32'h2000, 32'h5000_0000, 32'h80, 26'h20, 1, -1, 0, 0);
    if (cap_w.size() > 0) chk("lit_self_nxt", cap_w[0], 32'h2000);
    run_cmd(32'h3000, 32'hFFFF_FC00, 32'h400, 26'h3FF_FFFF, 2, -1, 1, 0);
    if (cap_w.size() > 10) chk("lit_buf_wrap", cap_w[10], 32'h0);

    // Reset while the 5th data beat is pending
    clear_mon(); err_at = -1; bp = 0;
    build(32'h1000, 32'h4000_0000, 32'h400, 26'h100, 3, -1, k);
    @(posedge clk); #1;
    desc_base = 32'h1000; buf_base = 32'h4000_0000; buf_stride = 32'h400;
    xfer_len = 26'h100; desc_count = 8'd3; start = 1;
    @(posedge clk); #1 start = 0;
    k = 0;
    while (cap_w.size() < 4 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("reset_wait_timeout", 0, 1);
    #2 rst_n = 0; #1;
    chk_reset_outs();
    clear_mon(); bvalid = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    run_cmd(32'h1000, 32'h4000_0000, 32'h400, 26'h100, 3, -1, 0, 0);
    chk_ring3();

    for (int r = 0; r < 8; r++) begin
      int c, e;
      c = $urandom_range(0, 5);
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
      run_cmd($urandom() & 32'hFFFF_FFC0, $urandom(), $urandom(), 26'($urandom()),
              c, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
